// File: rtl/uart_tx_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port_if
//  Description : IO-bus bundle between the core and the UART transmit port.
//                master = core side (drives address/data/strobe, reads CSR),
//                slave  = peripheral side.
//  Signals     : io_addr[7:0]           register address
//                io_data[31:0]          write data
//                io_we                  one-cycle write strobe
//                io_uart_csr_reg[31:0]  registered status word
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_port_if;
  logic [7:0]  io_addr;
  logic [31:0] io_data;
  logic        io_we;
  logic [31:0] io_uart_csr_reg;

  modport master (
    output io_addr,
    output io_data,
    output io_we,
    input  io_uart_csr_reg
  );

  modport slave (
    input  io_addr,
    input  io_data,
    input  io_we,
    output io_uart_csr_reg
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_port
//  Description : Memory-mapped UART transmitter. Byte writes to DATA_ADDR are
//                buffered and sent as 8N1 frames on tx; CSR_ADDR bit3 write
//                clears the sticky overrun flag.
//  Ports       : clk       system clock
//                rst       asynchronous active-high reset
//                bus       uart_tx_port_if.slave (io_addr, io_data, io_we,
//                          io_uart_csr_reg)
//                tx        serial output, idles high, registered
//  CSR         : bit0 busy, bit1 full, bit2 empty, bit3 overrun (sticky)
//  Config      : UART_TX_FIFO_EN defined   -> FIFO_DEPTH-entry circular FIFO
//                UART_TX_FIFO_EN undefined -> single holding register
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
  parameter int          CLK_DIV    = 16,
  parameter logic [7:0]  DATA_ADDR  = 8'h00,
  parameter logic [7:0]  CSR_ADDR   = 8'h01,
  parameter int          FIFO_DEPTH = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  uart_tx_port_if.slave  bus,
  output logic           tx
);

  localparam int                 c_CNT_W     = $clog2(CLK_DIV);
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic w_data_wr;
  logic w_csr_clr;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_full;
  logic w_empty;
  logic w_full_d;
  logic w_empty_d;
  logic [7:0] w_head;

  assign w_data_wr = bus.io_we && (bus.io_addr == DATA_ADDR);
  assign w_csr_clr = bus.io_we && (bus.io_addr == CSR_ADDR) && bus.io_data[3];

  // A pop in the same cycle frees a slot, so a write into a full buffer is
  // still accepted then.
  assign w_push = w_data_wr && (!w_full || w_pop);
  assign w_drop = w_data_wr && w_full && !w_pop;

  // Upper data bits carry nothing for this peripheral.
  logic w_unused_data;
  assign w_unused_data = &{1'b0, bus.io_data[31:8]};

  // --------------------------------------------------------------------------
  // Byte buffer
  // --------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
  localparam int c_PTR_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]         fifo_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Extra MSB on each pointer distinguishes full from empty.
  assign wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[c_PTR_W-2:0] == rd_ptr_q[c_PTR_W-2:0]) &&
                     (wr_ptr_q[c_PTR_W-1]   != rd_ptr_q[c_PTR_W-1]);
  assign w_empty_d = (wr_ptr_d == rd_ptr_d);
  assign w_full_d  = (wr_ptr_d[c_PTR_W-2:0] == rd_ptr_d[c_PTR_W-2:0]) &&
                     (wr_ptr_d[c_PTR_W-1]   != rd_ptr_d[c_PTR_W-1]);
  assign w_head    = fifo_q[rd_ptr_q[c_PTR_W-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q[c_PTR_W-2:0]] <= bus.io_data[7:0];
    end
  end
`else
  localparam int c_UNUSED_DEPTH = FIFO_DEPTH;

  logic [7:0] hold_q, hold_d;
  logic       valid_q, valid_d;

  assign valid_d   = w_push || (valid_q && !w_pop);
  assign hold_d    = w_push ? bus.io_data[7:0] : hold_q;

  assign w_full    = valid_q;
  assign w_empty   = !valid_q;
  assign w_full_d  = valid_d;
  assign w_empty_d = !valid_d;
  assign w_head    = hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Shifter FSM
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        csr_q, csr_d;
  logic               w_bit_end;

  assign w_bit_end = (cnt_q == c_BAUD_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = w_bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    w_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          shreg_d = w_head;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit when more data waits.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            shreg_d = w_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // tx is derived from the next state so the registered line changes on
    // the same edge as the state it represents.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[bit_d];
      default: tx_d = 1'b1;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    overrun_d = overrun_q;
    if (w_csr_clr) overrun_d = 1'b0;
    if (w_drop)    overrun_d = 1'b1;

    csr_d = {28'd0, overrun_d, w_empty_d, w_full_d, (state_d != S_IDLE)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
      csr_q     <= 32'h0000_0004;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
      csr_q     <= csr_d;
    end
  end

  assign tx                  = tx_q;
  assign bus.io_uart_csr_reg = csr_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_port.md
# uart_tx_port

- Memory-mapped UART transmit peripheral on the core's IO bus; the consuming end of the core's UART register writes.
- Accepts byte writes to the UART data register and CSR writes from the core via `io_addr`/`io_data`/`io_we`.
- Buffers bytes and serializes them as 8N1 frames on `tx`.
- Reports status back to the core through `io_uart_csr_reg`.

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per serial bit. Legal range is ≥2.
- `DATA_ADDR`, 8'h00: IO address of the TX data register.
- `CSR_ADDR`, 8'h01: IO address of the control/status register.
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥2. Used only when `UART_TX_FIFO_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `io_addr`  in  8  IO register address from the core.
- `io_data`  in  32  IO write data from the core.
- `io_we`  in  1  IO write strobe, one cycle per write.
- `io_uart_csr_reg`  out  32  status word, registered.
- `tx`  out  1  serial output, idles high.

## Operation
- **Data write** (`io_we`=1, `io_addr`=`DATA_ADDR`):
  - `io_data[7:0]` is pushed into the buffer. `io_data[31:8]` is ignored.
  - If the buffer is full and no pop happens in the same cycle, the byte is dropped and `overrun` is set.
- **CSR write** (`io_we`=1, `io_addr`=`CSR_ADDR`):
  - `io_data[3]`=1 clears `overrun`. All other bits are ignored.
- Writes to any other address are ignored.
- **CSR layout:**
  - bit0 `busy`: shifter not IDLE.
  - bit1 `full`: buffer full.
  - bit2 `empty`: buffer empty.
  - bit3 `overrun`: sticky.
  - bits[31:4] read 0.
- **Shifter FSM:** IDLE → START → DATA → STOP → (START | IDLE).
  - IDLE: `tx`=1. If buffer is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for `CLK_DIV` cycles.
  - DATA: 8 bits LSB first, each held `CLK_DIV` cycles. A 3-bit index counts 0..7.
  - STOP: `tx`=1 for `CLK_DIV` cycles. At the end, if the buffer is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- **Baud counter:**
  - Width `$clog2(CLK_DIV)`. Counts 0..`CLK_DIV`-1 and wraps.
  - Cleared on every state entry. A bit boundary occurs when the counter reaches `CLK_DIV`-1.
- **Simultaneous push and pop:** both succeed. Occupancy is unchanged, `full` is unchanged, and no overrun is flagged.
- **Simultaneous overrun-setting drop and CSR clear:** set wins.
- **`tx` registration:** `tx` is driven from a register, so there are no combinational glitches.

## Timing
- **Reset values:**
  - `tx`=1, `io_uart_csr_reg`=32'h0000_0004 (empty).
  - FSM in IDLE, buffer pointers and counters 0, `overrun`=0.
- **Reset assertion mid-frame:**
  - `tx` goes high immediately (asynchronously) and the buffer is flushed.
  - The partial frame is abandoned. After release, the FSM resumes from IDLE.
- **Write latency:**
  - A data write sampled at edge N updates the buffer and CSR at edge N (visible cycle N+1).
  - If the FSM was IDLE, the pop occurs at edge N+1 and `tx` falls after edge N+1.
  - The start bit therefore begins 1 cycle after the write.
- **Frame length:** exactly 10·`CLK_DIV` cycles from `tx` fall to end of stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop-bit cycle.
- **CSR timing:** `io_uart_csr_reg` reflects state after each edge. `busy` rises with the START entry and falls with the IDLE entry.

## Configuration
- **`UART_TX_FIFO_EN` defined:** the buffer is a `FIFO_DEPTH`-entry circular FIFO.
  - Read/write pointers are `$clog2(FIFO_DEPTH)`+1 bits wide and wrap modulo 2·depth.
  - `full` when the pointers' low bits match and their MSBs differ; `empty` when they are equal.
- **`UART_TX_FIFO_EN` undefined:** the buffer is a single holding register plus a valid flag, equivalent to depth 1.
  - `full` = valid, `empty` = !valid.
  - `FIFO_DEPTH` is ignored.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4 unless noted.
- **Reset:** assert `rst` mid-clock-phase → `tx`=1 and CSR=0x4 immediately. Write 0xA5 after reset → frame `tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles, start bit beginning 1 cycle after the write.
- **Back-to-back:** write 0x55 then 0x0F on consecutive cycles → two frames totalling 80 cycles with no idle gap. CSR `busy`=1 throughout, then CSR=0x4.
- **Overrun:**
  - With FIFO: write 6 bytes in 6 consecutive cycles. First pops at the edge after write 1, so the FIFO reaches 4 entries and the 6th byte is dropped → CSR=0x0B (busy|full|overrun) after the 6th write; 5 frames transmitted.
  - Without the macro: write 3 bytes → 3rd byte dropped, 2 frames transmitted.
- **Overrun clear:** CSR write 0x8 → `overrun` clears. Same-cycle overrun event with the CSR clear → `overrun` remains 1.
- **Push and pop same cycle:** full buffer; a data write lands on the stop-bit final cycle → byte accepted, `full` stays 1, `overrun` stays 0.
- **Reset mid-frame:** assert `rst` during the DATA bit-3 period → `tx` high immediately. Release, write 0x81 → clean frame; no residue of the earlier byte.
